// File: rtl/uart_rx_frame.sv
// uart_rx_frame: one-sample-per-bit serial frame receiver.
// The line is sampled once per clock. The receiver recognises a start bit (0),
// then DATA_BITS data bits sent LSB first, then one stop bit (1).
// A good frame produces a one-cycle valid pulse and updates data.
// A bad stop bit produces a one-cycle frame_err pulse and leaves data unchanged.
// All outputs come straight from flops, so there is no combinational path from signal.
module uart_rx_frame #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 signal,
    output logic                 valid,
    output logic [DATA_BITS-1:0] data,
    output logic                 frame_err
);

    // The counter is wide enough to hold DATA_BITS, so it never wraps mid-frame.
    localparam int CW = $clog2(DATA_BITS + 1);

    // WAIT_IDLE keeps a stuck-low line (after reset or after a framing error)
    // from being mistaken for a start bit. Only IDLE accepts a start bit.
    localparam logic [1:0] ST_WAIT_IDLE = 2'd0;
    localparam logic [1:0] ST_IDLE      = 2'd1;
    localparam logic [1:0] ST_DATA      = 2'd2;
    localparam logic [1:0] ST_STOP      = 2'd3;

    logic [1:0]           state_reg, state_next;
    logic [CW-1:0]        cnt_reg, cnt_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [DATA_BITS-1:0] data_reg, data_next;
    logic                 valid_reg, valid_next;
    logic                 ferr_reg, ferr_next;

    // Next-state logic: frame sequencing, data shifting and pulse generation.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        shift_next = shift_reg;
        data_next  = data_reg;
        valid_next = 1'b0;
        ferr_next  = 1'b0;
        case (state_reg)
            ST_WAIT_IDLE: begin
                if (signal) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (!signal) begin
                    state_next = ST_DATA;
                    cnt_next   = '0;
                end
            end
            ST_DATA: begin
                // Shift right and insert at the MSB. After DATA_BITS shifts,
                // the first bit received ends up in bit 0.
                shift_next = {signal, shift_reg[DATA_BITS-1:1]};
                cnt_next   = cnt_reg + CW'(1);
                if (cnt_reg == CW'(DATA_BITS - 1)) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (signal) begin
                    data_next  = shift_reg;
                    valid_next = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    ferr_next  = 1'b1;
                    state_next = ST_WAIT_IDLE;
                end
            end
            default: begin
                state_next = ST_WAIT_IDLE;
            end
        endcase
    end

    // State and output registers. The reset is asynchronous and active-low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_WAIT_IDLE;
            cnt_reg   <= '0;
            shift_reg <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            ferr_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            shift_reg <= shift_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
            ferr_reg  <= ferr_next;
        end
    end

    assign valid     = valid_reg;
    assign data      = data_reg;
    assign frame_err = ferr_reg;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed testbench for uart_rx_frame (DATA_BITS = 8).
// Each line bit is driven on the falling edge. Outputs are observed 1 ns after the rising edge.
module tb_uart_rx_frame;

    logic       clk;
    logic       reset;
    logic       signal;
    logic       valid;
    logic [7:0] data;
    logic       frame_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int vcount   = 0;
    int fcount   = 0;
    int vcyc_a   = 0;
    int vcyc_b   = 0;

    uart_rx_frame #(.DATA_BITS(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .signal    (signal),
        .valid     (valid),
        .data      (data),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("check %-16s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Drive one line bit and let the DUT sample it. Then record any pulses.
    task automatic drive(input logic b);
        @(negedge clk);
        signal = b;
        @(posedge clk);
        #1;
        cyc++;
        if (valid) begin
            vcount++;
            vcyc_a = vcyc_b;
            vcyc_b = cyc;
        end
        if (frame_err) fcount++;
        check("no_overlap", {31'd0, valid & frame_err}, 32'd0);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        drive(1'b0);
        for (int i = 0; i < 8; i++) drive(b[i]);
        drive(stop);
    endtask

    task automatic clear_counts();
        vcount = 0;
        fcount = 0;
    endtask

    initial begin
        reset  = 1'b0;
        signal = 1'b1;
        #2;
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_data", {24'd0, data}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Good frame. The line is idle, then the bits 0,1,0,0,0,1,1,1 are sent. The expected data is 0xE2.
        clear_counts();
        drive(1'b1);
        send_frame(8'hE2, 1'b1);
        check("e2_valid", {31'd0, valid}, 32'd1);
        check("e2_data", {24'd0, data}, 32'hE2);
        check("e2_ferr", {31'd0, frame_err}, 32'd0);
        check("e2_vcount", vcount, 1);
        drive(1'b1);
        check("e2_onecyc", {31'd0, valid}, 32'd0);

        // Bad stop bit carrying 0xA5. Expect frame_err and no change to data.
        clear_counts();
        send_frame(8'hA5, 1'b0);
        check("a5_ferr", {31'd0, frame_err}, 32'd1);
        check("a5_valid", {31'd0, valid}, 32'd0);
        check("a5_data", {24'd0, data}, 32'hE2);
        drive(1'b0);
        check("a5_ferr_1cyc", {31'd0, frame_err}, 32'd0);
        // A further 0 without a 1 first must not be taken as a start bit.
        for (int i = 0; i < 10; i++) drive(1'b1);
        check("nostart_vcnt", vcount, 0);
        check("nostart_fcnt", fcount, 1);

        // After the line returns to 1, a good frame with 0x3C is accepted.
        send_frame(8'h3C, 1'b1);
        check("3c_valid", {31'd0, valid}, 32'd1);
        check("3c_data", {24'd0, data}, 32'h3C);

        // Back-to-back frames 0x55 and 0xFF with no idle bit between them.
        drive(1'b1);
        clear_counts();
        send_frame(8'h55, 1'b1);
        check("b2b_data0", {24'd0, data}, 32'h55);
        send_frame(8'hFF, 1'b1);
        check("b2b_data1", {24'd0, data}, 32'hFF);
        check("b2b_vcount", vcount, 2);
        check("b2b_spacing", vcyc_b - vcyc_a, 10);

        // Reset in the middle of a frame. Expect no pulses, and data returns to 0.
        clear_counts();
        drive(1'b1);
        drive(1'b0);
        drive(1'b0);
        drive(1'b1);
        #1;
        reset = 1'b0;
        #1;
        check("mid_rst_data", {24'd0, data}, 32'd0);
        check("mid_rst_valid", {31'd0, valid}, 32'd0);
        check("mid_rst_pulses", vcount + fcount, 0);
        @(negedge clk);
        reset = 1'b1;

        // Incomplete frame followed by reset. valid must never rise.
        clear_counts();
        drive(1'b1); drive(1'b0); drive(1'b1); drive(1'b0);
        drive(1'b1); drive(1'b0); drive(1'b1); drive(1'b0);
        #1;
        reset = 1'b0;
        #1;
        check("inc_vcount", vcount, 0);
        check("inc_fcount", fcount, 0);

        // Release reset while the line is low. The block must stay in WAIT_IDLE.
        signal = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        clear_counts();
        for (int i = 0; i < 12; i++) drive(1'b0);
        check("low_vcount", vcount, 0);
        check("low_fcount", fcount, 0);
        check("low_data", {24'd0, data}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- Single-bit serial receiver that samples one bit per clock, with no oversampling.
- Detects and validates asynchronous 8N1 frames: a start bit (0), DATA_BITS data bits sent LSB first, then one stop bit (1).
- On a good frame it pulses valid for one cycle and presents the received byte.
- Sits behind the line synchroniser in the serial input path. Its outputs feed the receive FIFO and the error counters.

Parameters:
- DATA_BITS, default 8: number of data bits per frame. Legal range is 5 to 9.

Ports:
- clk  input  1  system clock; every input is sampled on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- signal  input  1  serial line; idle level is 1.
- valid  output  1  one-cycle pulse when a frame completes with a correct stop bit.
- data  output  DATA_BITS  last correctly received word; held stable between valid pulses.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled as 0.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset=0, asynchronous):
  - state goes to WAIT_IDLE.
  - valid=0, frame_err=0, data=0, bit counter=0, shift register=0.
- All outputs are registered. There is no combinational path from signal to any output.
- WAIT_IDLE:
  - Ignores 0s.
  - Sampling signal=1 moves to IDLE.
  - Purpose: a low line after reset or after a framing error is never mistaken for a start bit.
- IDLE:
  - Sampling signal=0 is a start bit: move to DATA and clear the bit counter.
  - Sampling signal=1 stays in IDLE.
- DATA:
  - Each edge shifts signal into the shift register LSB first; the first data bit lands in data[0].
  - After DATA_BITS samples, move to STOP.
  - The bit counter is clog2(DATA_BITS+1) wide and never wraps mid-frame.
- STOP, signal=1:
  - At the sampling edge, data <= shift register and valid <= 1.
  - Next state is IDLE.
- STOP, signal=0:
  - At the sampling edge, frame_err <= 1 and data is left unchanged.
  - Next state is WAIT_IDLE.
- Latency: valid and frame_err are high during the cycle immediately after the stop-bit sampling edge. Each stays high for exactly one cycle.
- Back-to-back frames: the edge after the stop-bit edge may sample the next start bit. No idle bit is needed between frames, and no frame is lost.
- Reset mid-frame:
  - The partial frame is discarded and no valid or frame_err pulse is produced.
  - data returns to 0 and the block re-enters WAIT_IDLE.
- A 0 is never treated as a start bit unless the block is in IDLE.
- valid and frame_err are never high in the same cycle.

Test Plan:
- Reset, then signal 1,0,0,1 (start plus 2 data bits), then assert reset. Required: valid=0 and frame_err=0 throughout; data=0 after reset.
- Reset, then 1,0,1,0,1,0,1,0 (incomplete frame), then reset. Required: valid stays 0 on every cycle.
- Reset, then 1, 0, 0,1,0,0,0,1,1,1, 1 (idle, start, 8 data bits, stop). Required: exactly one valid pulse on the cycle after the stop sample, data=0xE2, frame_err=0.
- Reset, then 1, start, data 0xA5 LSB first, stop=0. Required: one frame_err pulse, valid=0, data unchanged.
  - Then a 0 without an intervening 1. Required: no start is detected.
  - Then 1, followed by a good frame carrying 0x3C. Required: valid pulse with data=0x3C.
- Two back-to-back good frames carrying 0x55 then 0xFF, with no idle bit between. Required: two valid pulses exactly 10 cycles apart; data=0x55, then 0xFF.
- Hold reset low with signal=0, then release with signal held 0 for 12 cycles. Required: valid=0 and frame_err=0 throughout, because the block stays in WAIT_IDLE.
